// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter
//   Shares one DDR user-side read-burst port between two read clients
//   (ch0: FIR-tap vout buffer, ch1: secondary readback path). Arbitration
//   is round robin at burst granularity with a single burst in flight.
//   Returned beats go only to the granted client. A watchdog aborts a burst
//   that never finishes so the port cannot lock up.
//
// Ports (all in the ddr_clk_i domain):
//   ddr_clk_i, ddr_rst_i           clock, synchronous active-high reset
//   chN_rd_req_i/len_i/addr_i      client burst request (level, held to finish)
//   chN_rd_data_valid_o/data_o     returned beats (valid steered to grantee)
//   chN_rd_finish_o                one-cycle burst-complete pulse
//   rd_ddr_req_o/len_o/addr_o      request to DDR (level, held to finish)
//   rd_ddr_data_valid_i/data_i     beats from DDR
//   rd_ddr_finish_i                burst-done pulse from DDR
//   busy_o                         arbiter not idle
//   grant_o                        current / last granted client
//   timeout_o                      one-cycle pulse on watchdog abort
//   len_err_o                      sticky beat-count mismatch flag
module ddr_rd_arbiter #(
  parameter int  ADDR_WIDTH     = 30,
  parameter int  MEM_DATA_BITS  = 256,
  parameter int  TIMEOUT_CYCLES = 4096,
  // Clock-to-q delay used by behavioural models around this block; the
  // synthesizable logic here applies no delays.
  parameter real TCQ            = 0.1
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_i,

  input  logic                     ch0_rd_req_i,
  input  logic [7:0]               ch0_rd_len_i,
  input  logic [ADDR_WIDTH-1:0]    ch0_rd_addr_i,
  output logic                     ch0_rd_data_valid_o,
  output logic [MEM_DATA_BITS-1:0] ch0_rd_data_o,
  output logic                     ch0_rd_finish_o,

  input  logic                     ch1_rd_req_i,
  input  logic [7:0]               ch1_rd_len_i,
  input  logic [ADDR_WIDTH-1:0]    ch1_rd_addr_i,
  output logic                     ch1_rd_data_valid_o,
  output logic [MEM_DATA_BITS-1:0] ch1_rd_data_o,
  output logic                     ch1_rd_finish_o,

  output logic                     rd_ddr_req_o,
  output logic [7:0]               rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
  input  logic                     rd_ddr_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
  input  logic                     rd_ddr_finish_i,

  output logic                     busy_o,
  output logic                     grant_o,
  output logic                     timeout_o,
  output logic                     len_err_o
);

  generate
    if (TIMEOUT_CYCLES < 2 || TCQ < 0.0) begin : g_bad_param
      $error("ddr_rd_arbiter: TIMEOUT_CYCLES must be >= 2 and TCQ >= 0");
    end
  endgenerate

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state;
  logic [8:0]      beat_cnt;
  logic [WD_W-1:0] wdog;

  logic            pick;
  logic [8:0]      beats_at_finish;
  logic [8:0]      expected_beats;

  always_comb begin
    // With both clients requesting, the one not served last time wins.
    pick            = (ch0_rd_req_i & ch1_rd_req_i) ? ~grant_o : ch1_rd_req_i;
    // A beat arriving together with finish still belongs to the burst.
    beats_at_finish = beat_cnt + {8'd0, rd_ddr_data_valid_i};
    // Length 0 encodes a full 256-beat burst.
    expected_beats  = (rd_ddr_len_o == 8'd0) ? 9'd256 : {1'b0, rd_ddr_len_o};
  end

  // Beats are steered with zero latency; data is broadcast and qualified
  // by the per-client valid.
  assign ch0_rd_data_valid_o = rd_ddr_data_valid_i & (state == BURST) & ~grant_o;
  assign ch1_rd_data_valid_o = rd_ddr_data_valid_i & (state == BURST) &  grant_o;
  assign ch0_rd_data_o       = rd_ddr_data_i;
  assign ch1_rd_data_o       = rd_ddr_data_i;
  assign busy_o              = (state != IDLE);

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      state           <= IDLE;
      rd_ddr_req_o    <= 1'b0;
      rd_ddr_len_o    <= '0;
      rd_ddr_addr_o   <= '0;
      grant_o         <= 1'b1;  // ch0 wins the first contention
      ch0_rd_finish_o <= 1'b0;
      ch1_rd_finish_o <= 1'b0;
      timeout_o       <= 1'b0;
      len_err_o       <= 1'b0;
      beat_cnt        <= '0;
      wdog            <= '0;
    end else begin
      ch0_rd_finish_o <= 1'b0;
      ch1_rd_finish_o <= 1'b0;
      timeout_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (ch0_rd_req_i | ch1_rd_req_i) begin
            state         <= BURST;
            rd_ddr_req_o  <= 1'b1;
            grant_o       <= pick;
            rd_ddr_len_o  <= pick ? ch1_rd_len_i  : ch0_rd_len_i;
            rd_ddr_addr_o <= pick ? ch1_rd_addr_i : ch0_rd_addr_i;
            beat_cnt      <= '0;
            wdog          <= '0;
          end
        end
        BURST: begin
          if (rd_ddr_data_valid_i) begin
            beat_cnt <= beat_cnt + 9'd1;
          end
          // Finish wins over a watchdog expiry in the same cycle.
          if (rd_ddr_finish_i) begin
            state           <= DONE;
            rd_ddr_req_o    <= 1'b0;
            ch0_rd_finish_o <= ~grant_o;
            ch1_rd_finish_o <=  grant_o;
            if (beats_at_finish != expected_beats) begin
              len_err_o <= 1'b1;
            end
          end else if (wdog == WD_LAST) begin
            state           <= DONE;
            rd_ddr_req_o    <= 1'b0;
            ch0_rd_finish_o <= ~grant_o;
            ch1_rd_finish_o <=  grant_o;
            timeout_o       <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          // One idle cycle so the client can drop its request.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Testbench for ddr_rd_arbiter: directed scenarios with literal expectations
// followed by randomized client/DDR traffic, all continuously checked against
// a transaction-level model of the arbiter.
module tb_ddr_rd_arbiter;

  localparam int AW = 30;
  localparam int DW = 256;
  localparam int TO = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, req1;
  logic [7:0]    len0, len1;
  logic [AW-1:0] addr0, addr1;
  logic          ddr_valid, ddr_fin;
  logic [DW-1:0] ddr_data;

  logic          ch0_rd_data_valid_o, ch1_rd_data_valid_o;
  logic [DW-1:0] ch0_rd_data_o, ch1_rd_data_o;
  logic          ch0_rd_finish_o, ch1_rd_finish_o;
  logic          rd_ddr_req_o;
  logic [7:0]    rd_ddr_len_o;
  logic [AW-1:0] rd_ddr_addr_o;
  logic          busy_o, grant_o, timeout_o, len_err_o;

  ddr_rd_arbiter #(
    .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .TIMEOUT_CYCLES(TO), .TCQ(0.1)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_i(rst),
    .ch0_rd_req_i(req0), .ch0_rd_len_i(len0), .ch0_rd_addr_i(addr0),
    .ch0_rd_data_valid_o(ch0_rd_data_valid_o), .ch0_rd_data_o(ch0_rd_data_o),
    .ch0_rd_finish_o(ch0_rd_finish_o),
    .ch1_rd_req_i(req1), .ch1_rd_len_i(len1), .ch1_rd_addr_i(addr1),
    .ch1_rd_data_valid_o(ch1_rd_data_valid_o), .ch1_rd_data_o(ch1_rd_data_o),
    .ch1_rd_finish_o(ch1_rd_finish_o),
    .rd_ddr_req_o(rd_ddr_req_o), .rd_ddr_len_o(rd_ddr_len_o),
    .rd_ddr_addr_o(rd_ddr_addr_o),
    .rd_ddr_data_valid_i(ddr_valid), .rd_ddr_data_i(ddr_data),
    .rd_ddr_finish_i(ddr_fin),
    .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o),
    .len_err_o(len_err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A burst is described by who owns it, when it was granted and how many
  // beats it has seen; the gap after a burst is derived from the edge index
  // at which it ended.
  int            edge_no  = 0;
  bit            cmp_en   = 0;
  bit            m_active = 0, m_owner = 0, m_last = 1;
  int            m_start  = 0, m_end = -10, m_beats = 0;
  logic [7:0]    m_len    = '0;
  logic [AW-1:0] m_addr   = '0;
  bit            m_fin0 = 0, m_fin1 = 0, m_to = 0, m_err = 0;

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      cmp_en = 1; m_active = 0; m_last = 1; m_owner = 0; m_end = -10;
      m_len = '0; m_addr = '0; m_fin0 = 0; m_fin1 = 0; m_to = 0; m_err = 0;
    end else begin
      m_fin0 = 0; m_fin1 = 0; m_to = 0;
      if (m_active) begin
        if (ddr_valid) m_beats++;
        if (ddr_fin || (edge_no - m_start) == TO) begin
          m_active = 0; m_end = edge_no;
          if (m_owner) m_fin1 = 1; else m_fin0 = 1;
          if (ddr_fin) begin
            if (m_beats != ((m_len == 0) ? 256 : int'(m_len))) m_err = 1;
          end else begin
            m_to = 1;
          end
        end
      end else if (edge_no >= m_end + 2 && (req0 || req1)) begin
        m_owner  = (req0 && req1) ? !m_last : req1;
        m_last   = m_owner;
        m_len    = m_owner ? len1 : len0;
        m_addr   = m_owner ? addr1 : addr0;
        m_active = 1; m_start = edge_no; m_beats = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req",     rd_ddr_req_o, m_active);
      chk("busy",    busy_o, m_active || (edge_no == m_end));
      chk("grant",   grant_o, m_last);
      chk("len",     rd_ddr_len_o, m_len);
      chk("addr",    rd_ddr_addr_o, m_addr);
      chk("fin0",    ch0_rd_finish_o, m_fin0);
      chk("fin1",    ch1_rd_finish_o, m_fin1);
      chk("timeout", timeout_o, m_to);
      chk("len_err", len_err_o, m_err);
      chk("valid0",  ch0_rd_data_valid_o, ddr_valid && m_active && !m_owner);
      chk("valid1",  ch1_rd_data_valid_o, ddr_valid && m_active &&  m_owner);
      if (ddr_valid && m_active) begin
        if (m_owner) chk("data1", ch1_rd_data_o, ddr_data);
        else         chk("data0", ch0_rd_data_o, ddr_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < DW / 32; i++) ddr_data[i*32 +: 32] = $urandom;
  endtask

  // DDR returns nb beats, finish coincident with the last one.
  task automatic ddr_burst(input int nb);
    for (int i = 0; i < nb; i++) begin
      ddr_valid = 1; rand_data(); ddr_fin = (i == nb - 1);
      step();
    end
    if (nb == 0) begin ddr_fin = 1; step(); end
    ddr_valid = 0; ddr_fin = 0;
  endtask

  task automatic wait_req(input string name);
    int w;
    w = 0;
    while (!rd_ddr_req_o && w < 20) begin step(); w++; end
    chk(name, (w < 20), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  int n;
  bit in_b, fdone, hang;
  int sent, tgt, mode;

  initial begin
    rst = 1; req0 = 0; req1 = 0; len0 = 0; len1 = 0; addr0 = 0; addr1 = 0;
    ddr_valid = 0; ddr_fin = 0; ddr_data = '0;
    step(); step();
    chk("rst_grant", grant_o, 1'b1);
    chk("rst_req",   rd_ddr_req_o, 1'b0);
    chk("rst_busy",  busy_o, 1'b0);
    rst = 0;

    // Single ch0 burst, 4 beats.
    req0 = 1; len0 = 8'd4; addr0 = 30'h100;
    step();
    chk("t1_req",   rd_ddr_req_o, 1'b1);
    chk("t1_addr",  rd_ddr_addr_o, 30'h100);
    chk("t1_grant", grant_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ddr_valid = 1; rand_data(); #1;
      chk("t1_v0", ch0_rd_data_valid_o, 1'b1);
      chk("t1_v1", ch1_rd_data_valid_o, 1'b0);
      step();
    end
    ddr_valid = 0; ddr_fin = 1;
    step();
    ddr_fin = 0; req0 = 0;
    chk("t1_fin0", ch0_rd_finish_o, 1'b1);
    chk("t1_req_low", rd_ddr_req_o, 1'b0);
    chk("t1_lenerr", len_err_o, 1'b0);
    step();
    chk("t1_idle", busy_o, 1'b0);
    chk("t1_fin_pulse", ch0_rd_finish_o, 1'b0);

    // Round robin with both clients holding requests.
    do_reset();
    req0 = 1; len0 = 8'd2; addr0 = 30'h200;
    req1 = 1; len1 = 8'd2; addr1 = 30'h300;
    wait_req("t2_wait0");
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", grant_o, k[0]);
      chk("t2_addr",  rd_ddr_addr_o, k[0] ? 30'h300 : 30'h200);
      ddr_burst(2);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end else begin
        n = 1;
        while (!rd_ddr_req_o && n < 10) begin step(); n++; end
        chk("t2_turnaround", n, 3);
      end
    end
    step(); step();

    // ch1 short burst sets the sticky length error.
    req1 = 1; len1 = 8'd8; addr1 = 30'h400;
    wait_req("t3_wait");
    chk("t3_grant", grant_o, 1'b1);
    ddr_burst(7);
    chk("t3_fin1", ch1_rd_finish_o, 1'b1);
    chk("t3_lenerr", len_err_o, 1'b1);
    req1 = 0; step(); step();
    req1 = 1; len1 = 8'd3;
    wait_req("t3_wait2");
    ddr_burst(3);
    req1 = 0; step();
    chk("t3_sticky", len_err_o, 1'b1);
    step();

    // Watchdog abort, then ch1 is served.
    req0 = 1; len0 = 8'd4; addr0 = 30'h500;
    step();
    chk("t4_req", rd_ddr_req_o, 1'b1);
    req1 = 1; len1 = 8'd2; addr1 = 30'h600;
    n = 0;
    while (rd_ddr_req_o && n < 40) begin step(); n++; end
    chk("t4_cycles", n, TO);
    chk("t4_timeout", timeout_o, 1'b1);
    chk("t4_fin0", ch0_rd_finish_o, 1'b1);
    req0 = 0;
    step();
    chk("t4_to_pulse", timeout_o, 1'b0);
    wait_req("t4_wait1");
    chk("t4_grant1", grant_o, 1'b1);
    chk("t4_addr1",  rd_ddr_addr_o, 30'h600);
    ddr_burst(2);
    req1 = 0; step(); step();

    // Stray DDR activity while idle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ddr_valid = 1; ddr_fin = 1; rand_data(); #1;
      chk("t5_v0", ch0_rd_data_valid_o, 1'b0);
      chk("t5_v1", ch1_rd_data_valid_o, 1'b0);
      step();
      chk("t5_fin", {ch0_rd_finish_o, ch1_rd_finish_o, busy_o}, 3'b000);
    end
    ddr_valid = 0; ddr_fin = 0;
    req0 = 1; len0 = 8'd2; addr0 = 30'h700;
    wait_req("t5_wait");
    ddr_burst(2);
    req0 = 0;
    chk("t5_lenerr", len_err_o, 1'b0);
    step(); step();

    // Reset in the middle of a burst.
    req0 = 1; len0 = 8'd8; addr0 = 30'h800;
    wait_req("t6_wait");
    for (int i = 0; i < 3; i++) begin ddr_valid = 1; rand_data(); step(); end
    rst = 1;
    step();
    chk("t6_req",   rd_ddr_req_o, 1'b0);
    chk("t6_grant", grant_o, 1'b1);
    chk("t6_busy",  busy_o, 1'b0);
    chk("t6_addr",  rd_ddr_addr_o, 30'h0);
    chk("t6_v0",    ch0_rd_data_valid_o, 1'b0);
    rst = 0; req0 = 0;
    step(); step();
    ddr_valid = 0;
    req1 = 1; len1 = 8'd2; addr1 = 30'h900;
    wait_req("t6_wait1");
    chk("t6_grant1", grant_o, 1'b1);
    ddr_burst(2);
    req1 = 0;
    chk("t6_lenerr", len_err_o, 1'b0);
    step(); step();

    // Randomized traffic.
    in_b = 0; fdone = 0; hang = 0; sent = 0; tgt = 0;
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 699) == 0);
      if (!req0) begin
        if ($urandom_range(0, 3) == 0) begin
          req0 = 1; addr0 = AW'($urandom);
          len0 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        end
      end else if (ch0_rd_finish_o && $urandom_range(0, 3) != 0) begin
        req0 = 0;
      end
      if (!req1) begin
        if ($urandom_range(0, 3) == 0) begin
          req1 = 1; addr1 = AW'($urandom);
          len1 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        end
      end else if (ch1_rd_finish_o && $urandom_range(0, 3) != 0) begin
        req1 = 0;
      end
      rand_data();
      if (!rd_ddr_req_o) begin
        in_b = 0;
        ddr_valid = ($urandom_range(0, 7) == 0);
        ddr_fin   = ($urandom_range(0, 7) == 0);
      end else begin
        if (!in_b) begin
          in_b = 1; sent = 0; fdone = 0;
          tgt  = (rd_ddr_len_o == 0) ? 256 : int'(rd_ddr_len_o);
          mode = $urandom_range(0, 7);
          hang = (mode == 0);
          if (mode == 1) tgt--;
          else if (mode == 2) tgt++;
        end
        ddr_valid = 0; ddr_fin = 0;
        if (!fdone) begin
          if (sent < tgt && $urandom_range(0, 3) != 0) begin
            ddr_valid = 1; sent++;
          end
          if (sent == tgt && !hang && $urandom_range(0, 2) != 0) begin
            ddr_fin = 1; fdone = 1;
          end
        end
      end
      step();
    end
    rst = 0; req0 = 0; req1 = 0; ddr_valid = 0; ddr_fin = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
- Shares the single DDR read-burst interface (req/len/addr in, data_valid/data/finish back) between two read clients: ch0 (FIR-tap vout buffer) and ch1 (secondary readback path).
- Round-robin arbitration at burst granularity: one burst in flight at a time.
- Returned beats are steered to the granted client only; a watchdog prevents a hung burst from locking the interface.
- Sits between the client buffer controllers and the DDR user-side read port, in the ddr_clk_i domain.

Parameters:
- ADDR_WIDTH, 30, DDR address width.
- MEM_DATA_BITS, 256, DDR read data width.
- TIMEOUT_CYCLES, 4096, max cycles in BURST before abort; must be ≥ 2.
- TCQ, 0.1, simulation clock-to-q delay.

Ports:
- ddr_clk_i  in  1  sole clock.
- ddr_rst_i  in  1  synchronous, active-high reset.
- ch0_rd_req_i  in  1  level; held until ch0_rd_finish_o.
- ch0_rd_len_i  in  8  burst length in beats; stable while req high.
- ch0_rd_addr_i  in  ADDR_WIDTH  start address; stable while req high.
- ch0_rd_data_valid_o  out  1  beat valid for ch0.
- ch0_rd_data_o  out  MEM_DATA_BITS  beat data.
- ch0_rd_finish_o  out  1  one-cycle burst-complete pulse.
- ch1_rd_req_i / ch1_rd_len_i / ch1_rd_addr_i / ch1_rd_data_valid_o / ch1_rd_data_o / ch1_rd_finish_o: same as ch0.
- rd_ddr_req_o  out  1  level to DDR; held until finish.
- rd_ddr_len_o  out  8  latched length of granted client.
- rd_ddr_addr_o  out  ADDR_WIDTH  latched address of granted client.
- rd_ddr_data_valid_i  in  1  DDR beat valid.
- rd_ddr_data_i  in  MEM_DATA_BITS  DDR beat data.
- rd_ddr_finish_i  in  1  DDR burst-done pulse.
- busy_o  out  1  state ≠ IDLE.
- grant_o  out  1  index of current/last granted client.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- len_err_o  out  1  sticky; set on beat-count mismatch at finish; cleared only by reset.

Behaviour:
- Reset (synchronous, ddr_rst_i high at a clock edge; also valid mid-burst):
  - State goes to IDLE; rd_ddr_req_o=0, len/addr=0.
  - All chN outputs 0, busy_o=0, timeout_o=0, len_err_o=0.
  - grant_o=1, so ch0 wins the first contention.
  - Beat counter and watchdog cleared.
  - In-flight DDR beats after reset are dropped.
- States: IDLE, BURST, DONE.
- IDLE:
  - A req sampled high at edge N moves the FSM to BURST.
  - At N+1: rd_ddr_req_o=1, and len/addr/grant_o are registered from the winner.
  - Only one req high: that client wins.
  - Both high: winner = ~grant_o (round robin).
- BURST:
  - rd_ddr_req_o held high; len/addr stable.
  - chN_rd_data_valid_o = rd_ddr_data_valid_i & (state==BURST) & (grant_o==N), combinational, zero latency.
  - chN_rd_data_o = rd_ddr_data_i, broadcast to both clients.
  - 9-bit beat counter increments per valid beat.
  - Valid beats outside BURST are dropped and not counted.
  - Watchdog increments every BURST cycle.
- Finish: rd_ddr_finish_i sampled high in BURST:
  - Next cycle: rd_ddr_req_o=0, chN_rd_finish_o=1 for granted N (one cycle), state=DONE.
  - If beat count (including a beat coincident with finish) ≠ latched len, set len_err_o.
  - len=0 is treated as 256 beats.
- Watchdog: counter reaches TIMEOUT_CYCLES-1 without finish:
  - Same exit as finish; additionally timeout_o=1 for one cycle.
  - len_err_o not updated.
- Finish and watchdog expiry in the same cycle: finish takes priority; no timeout.
- DONE: one-cycle gap so the client can drop req.
  - Returns to IDLE; req is not sampled in DONE.
  - Minimum back-to-back turnaround: finish edge → next rd_ddr_req_o high = 3 cycles.
- A client dropping req mid-BURST is ignored; the burst completes normally.
- rd_ddr_finish_i outside BURST is ignored.
- Starvation bound: a continuously requesting client waits at most one foreign burst.

Test Plan:
- Reset, then ch0 req (addr=0x100, len=4), DDR returns 4 beats + finish → rd_ddr_req_o high 1 cycle after req; ch0 sees 4 valid beats, ch1 none; ch0_rd_finish_o one pulse; len_err_o=0; busy_o low 2 cycles after finish.
- ch0 and ch1 req in the same cycle, each len=2, both held high → grant order ch0, ch1, ch0, ch1; rd_ddr_addr_o alternates; 3-cycle finish-to-req turnaround.
- ch1 burst len=8, DDR returns 7 beats then finish → ch1_rd_finish_o pulses; len_err_o sets and stays 1 through a following correct burst.
- TIMEOUT_CYCLES=16, ch0 req, no finish → rd_ddr_req_o drops 16 cycles after assertion; timeout_o and ch0_rd_finish_o pulse together; ch1 req then granted normally.
- Stray rd_ddr_data_valid_i and rd_ddr_finish_i in IDLE → no chN valid/finish pulses, counters unchanged.
- ddr_rst_i asserted 3 beats into a len=8 ch0 burst → next cycle all outputs 0, grant_o=1; after release, a new ch1 req is granted with a clean beat count.
